// File: rtl/inv_modular_seq_if.sv
// Request/response bundle for the sequential modular inverter.
// cycles_o exists only when INV_CYCLE_COUNT_EN is defined.
interface inv_modular_seq_if #(
  parameter int unsigned WIDTH = 64
) ();

  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] p_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             error_o;
`ifdef INV_CYCLE_COUNT_EN
  logic [15:0]      cycles_o;
`endif

  modport master (
    output start_i, a_i, p_i,
`ifdef INV_CYCLE_COUNT_EN
    input  cycles_o,
`endif
    input  ready_o, done_o, result_o, error_o
  );

  modport slave (
    input  start_i, a_i, p_i,
`ifdef INV_CYCLE_COUNT_EN
    output cycles_o,
`endif
    output ready_o, done_o, result_o, error_o
  );

endinterface

// File: rtl/inv_modular_seq.sv
// Sequential modular inverse (binary extended Euclid), one step per CALC cycle.
// Optional step-count output enabled by defining INV_CYCLE_COUNT_EN.
module inv_modular_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  inv_modular_seq_if.slave   bus
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] u_q, u_d, v_q, v_d, p_q, p_d;
  logic [XW-1:0]    x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
`ifdef INV_CYCLE_COUNT_EN
  logic [CW-1:0]    steps_q, steps_d;
  logic [CW-1:0]    hold_q, hold_d;
  logic [CW-1:0]    cycles_q, cycles_d;
`endif

  logic             precheck_err_c;
  logic             hit_u_c, hit_v_c, zero_c;
  logic [XW-1:0]    p_ext_c;
  logic [XW-1:0]    x_half_c, y_half_c, x_sub_c, y_sub_c;

  // Operand legality and per-cycle termination conditions
  always_comb begin
    precheck_err_c = (bus.a_i == '0) || !bus.p_i[0] ||
                     (bus.p_i < WIDTH'(3)) || (bus.a_i >= bus.p_i);
    hit_u_c        = (u_q == WIDTH'(1));
    hit_v_c        = (v_q == WIDTH'(1));
    zero_c         = (u_q == '0) || (v_q == '0);
  end

  // Coefficient updates kept in [0,P-1]; XW bits absorb x+P
  always_comb begin
    p_ext_c  = XW'(p_q);
    x_half_c = x_q[0] ? ((x_q + p_ext_c) >> 1) : (x_q >> 1);
    y_half_c = y_q[0] ? ((y_q + p_ext_c) >> 1) : (y_q >> 1);
    x_sub_c  = (x_q >= y_q) ? (x_q - y_q) : (x_q + p_ext_c - y_q);
    y_sub_c  = (y_q >= x_q) ? (y_q - x_q) : (y_q + p_ext_c - x_q);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = precheck_err_c ? DONE : CALC;
        end
      end
      CALC: begin
        if (hit_u_c || hit_v_c || zero_c) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    u_d      = u_q;
    v_d      = v_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    result_d = result_q;
    error_d  = error_q;
    ready_d  = (state_d == IDLE);
    done_d   = (state_q == DONE);
`ifdef INV_CYCLE_COUNT_EN
    steps_d  = steps_q;
    hold_d   = hold_q;
    cycles_d = cycles_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          p_d      = bus.p_i;
          result_d = '0;
          error_d  = precheck_err_c;
`ifdef INV_CYCLE_COUNT_EN
          steps_d  = '0;
          hold_d   = '0;
`endif
          if (precheck_err_c) begin
            u_d = '0;
            v_d = '0;
            x_d = '0;
            y_d = '0;
          end else begin
            u_d = bus.a_i;
            v_d = bus.p_i;
            x_d = XW'(1);
            y_d = '0;
          end
        end
      end
      CALC: begin
        if (hit_u_c || hit_v_c) begin
          result_d = hit_u_c ? x_q[WIDTH-1:0] : y_q[WIDTH-1:0];
          error_d  = 1'b0;
`ifdef INV_CYCLE_COUNT_EN
          hold_d   = steps_q;
          steps_d  = '0;
`endif
        end else if (zero_c) begin
          result_d = '0;
          error_d  = 1'b1;
`ifdef INV_CYCLE_COUNT_EN
          hold_d   = steps_q;
          steps_d  = '0;
`endif
        end else begin
          if (!u_q[0]) begin
            u_d = u_q >> 1;
            x_d = x_half_c;
          end else if (!v_q[0]) begin
            v_d = v_q >> 1;
            y_d = y_half_c;
          end else if (u_q >= v_q) begin
            u_d = u_q - v_q;
            x_d = x_sub_c;
          end else begin
            v_d = v_q - u_q;
            y_d = y_sub_c;
          end
`ifdef INV_CYCLE_COUNT_EN
          steps_d = (steps_q == '1) ? steps_q : steps_q + CW'(1);
`endif
        end
      end
      DONE: begin
`ifdef INV_CYCLE_COUNT_EN
        cycles_d = hold_q;
`endif
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      u_q      <= '0;
      v_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef INV_CYCLE_COUNT_EN
      steps_q  <= '0;
      hold_q   <= '0;
      cycles_q <= '0;
`endif
    end else begin
      u_q      <= u_d;
      v_q      <= v_d;
      x_q      <= x_d;
      y_q      <= y_d;
      p_q      <= p_d;
      result_q <= result_d;
      error_q  <= error_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef INV_CYCLE_COUNT_EN
      steps_q  <= steps_d;
      hold_q   <= hold_d;
      cycles_q <= cycles_d;
`endif
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.error_o  = error_q;
`ifdef INV_CYCLE_COUNT_EN
  assign bus.cycles_o = cycles_q;
`endif

endmodule

// File: tb/tb_inv_modular_seq.sv
// Directed bench for inv_modular_seq with hand-computed inverses and latencies.
module tb_inv_modular_seq;

  localparam int unsigned WIDTH = 64;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   errors;
  int   lat;
  int   lat2;
  logic early;
  logic stray;

  inv_modular_seq_if #(.WIDTH(WIDTH)) bus ();

  inv_modular_seq #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request and returns cycles from accept edge to done_o (-1 on timeout)
  task automatic run_op(input logic [63:0] a, input logic [63:0] p, output int latency);
    int n;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    bus.a_i     = a;
    bus.p_i     = p;
    bus.start_i = 1'b1;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    latency = -1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk_i); #1;
      if (bus.done_o === 1'b1) begin
        latency = c;
        break;
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_ni      = 1'b0;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.p_i     = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", 64'(bus.ready_o), 64'd1);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_error", 64'(bus.error_o), 64'd0);
    check("rst_result", bus.result_o, 64'd0);
`ifdef INV_CYCLE_COUNT_EN
    check("rst_cycles", 64'(bus.cycles_o), 64'd0);
`endif
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_op(64'd3, 64'd7, lat);
    check("3_7_lat", 64'(lat), 64'd5);
    check("3_7_res", bus.result_o, 64'd5);
    check("3_7_err", 64'(bus.error_o), 64'd0);
`ifdef INV_CYCLE_COUNT_EN
    check("3_7_cycles", 64'(bus.cycles_o), 64'd3);
`endif
    @(posedge clk_i); #1;
    check("3_7_pulse", 64'(bus.done_o), 64'd0);
    check("3_7_hold", bus.result_o, 64'd5);
    check("3_7_ready", 64'(bus.ready_o), 64'd1);

    run_op(64'd1, 64'd7, lat);
    check("1_7_lat", 64'(lat), 64'd2);
    check("1_7_res", bus.result_o, 64'd1);
`ifdef INV_CYCLE_COUNT_EN
    check("1_7_cycles", 64'(bus.cycles_o), 64'd0);
`endif

    run_op(64'd0, 64'd7, lat);
    check("0_7_lat", 64'(lat), 64'd1);
    check("0_7_err", 64'(bus.error_o), 64'd1);
    check("0_7_res", bus.result_o, 64'd0);

    run_op(64'd3, 64'd8, lat);
    check("p_even_lat", 64'(lat), 64'd1);
    check("p_even_err", 64'(bus.error_o), 64'd1);

    run_op(64'd7, 64'd7, lat);
    check("a_ge_p_lat", 64'(lat), 64'd1);
    check("a_ge_p_err", 64'(bus.error_o), 64'd1);

    run_op(64'd3, 64'd9, lat);
    check("3_9_lat", 64'(lat), 64'd5);
    check("3_9_err", 64'(bus.error_o), 64'd1);
    check("3_9_res", bus.result_o, 64'd0);
`ifdef INV_CYCLE_COUNT_EN
    check("3_9_cycles", 64'(bus.cycles_o), 64'd3);
`endif

    run_op(64'd2, 64'h1FFF_FFFF_FFFF_FFFF, lat);
    check("m61_lat", 64'(lat), 64'd3);
    check("m61_res", bus.result_o, 64'h1000_0000_0000_0000);
    check("m61_err", 64'(bus.error_o), 64'd0);

    run_op(64'd6, 64'd7, lat);
    check("6_7_lat", 64'(lat), 64'd6);
    check("6_7_res", bus.result_o, 64'd6);
`ifdef INV_CYCLE_COUNT_EN
    check("6_7_cycles", 64'(bus.cycles_o), 64'd4);
`endif

    run_op(64'd5, 64'd11, lat);
    check("5_11_lat", 64'(lat), 64'd6);
    check("5_11_res", bus.result_o, 64'd9);

    // start held high through CALC with other operands
    bus.a_i     = 64'd5;
    bus.p_i     = 64'd11;
    bus.start_i = 1'b1;
    @(posedge clk_i); #1;
    bus.a_i = 64'd3;
    bus.p_i = 64'd7;
    early   = 1'b0;
    lat     = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk_i); #1;
      if (bus.done_o === 1'b1) begin
        lat = c;
        break;
      end
      if (bus.ready_o === 1'b1) early = 1'b1;
    end
    check("ovl_lat", 64'(lat), 64'd6);
    check("ovl_res", bus.result_o, 64'd9);
    check("ovl_ready_low", 64'(early), 64'd0);
    lat2 = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk_i); #1;
      if (c == 1) begin
        bus.start_i = 1'b0;
        check("ovl2_accepted", 64'(bus.ready_o), 64'd0);
      end
      if (bus.done_o === 1'b1) begin
        lat2 = c;
        break;
      end
    end
    check("ovl2_lat", 64'(lat2), 64'd6);
    check("ovl2_res", bus.result_o, 64'd5);

    // reset in the middle of CALC
    @(posedge clk_i); #1;
    bus.a_i     = 64'd5;
    bus.p_i     = 64'd11;
    bus.start_i = 1'b1;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    @(posedge clk_i); #1;
    check("mid_busy", 64'(bus.ready_o), 64'd0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_ready", 64'(bus.ready_o), 64'd1);
    check("async_result", bus.result_o, 64'd0);
    check("async_done", 64'(bus.done_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    stray  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      if (bus.done_o !== 1'b0) stray = 1'b1;
    end
    check("no_stray_done", 64'(stray), 64'd0);
    run_op(64'd3, 64'd7, lat);
    check("post_rst_lat", 64'(lat), 64'd5);
    check("post_rst_res", bus.result_o, 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_modular_seq.md
INV_MODULAR_SEQ -- requirements
Module: inv_modular_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/modulus width in bits, legal range 8..256.
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request; accepted only while ready_o=1.
REQ-005 SHALL have port a_i  input  WIDTH  operand A; sampled on the accept edge.
REQ-006 SHALL have port p_i  input  WIDTH  modulus P; sampled on the accept edge.
REQ-007 SHALL have port ready_o  output  1  high in IDLE only.
REQ-008 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-009 SHALL have port result_o  output  WIDTH  A^-1 mod P; valid from done_o until the next accept.
REQ-010 SHALL have port error_o  output  1  operation had no inverse or illegal operands; same validity as result_o.

Function
REQ-011 SHALL implement the states IDLE, CALC and DONE.
REQ-012 IDLE with start_i=1 SHALL latch a_i/p_i. It SHALL go to DONE with error_o=1 and result_o=0 if a_i=0, p_i[0]=0, p_i<3 or a_i>=p_i. Otherwise it SHALL go to CALC with u=A, v=P, x=1, y=0.
REQ-013 Each CALC cycle SHALL first check u=1 or v=1. On a hit it SHALL latch result_o (x if u=1, else y), set error_o=0, clear the step count and go to DONE, with no step taken that cycle.
REQ-014 If u=0 or v=0 in a CALC cycle (gcd>1), the block SHALL go to DONE with error_o=1 and result_o=0.
REQ-015 Otherwise, exactly one step per CALC cycle, with priority:
- u even: u=u>>1; x=x>>1 if x even, else (x+P)>>1.
- else v even: same for v and y.
- else u>=v: u=u-v; x=x-y if x>=y, else x+P-y.
- else: v=v-u; y=y-x if y>=x, else y+P-x.
REQ-016 x and y SHALL be held in WIDTH+1 bits so that x+P cannot overflow. They SHALL stay in [0,P-1] after every step, so result_o is always in [1,P-1].
REQ-017 DONE SHALL assert done_o for exactly one cycle and SHALL return to IDLE on the next edge.
REQ-018 start_i SHALL be ignored in CALC and DONE, with no queuing.
REQ-019 Latency SHALL be 1 cycle (error precheck) or S+2 cycles from the accept edge to done_o, where S is the number of steps. S SHALL be at most 4*WIDTH.
REQ-020 result_o and error_o SHALL hold their values through IDLE and change only on the next accept.

Reset
REQ-021 On rst_ni low, the block SHALL go to IDLE immediately, regardless of clock.
REQ-022 Reset SHALL set ready_o=1, done_o=0, error_o=0 and result_o=0, and clear u, v, x, y and all counters.
REQ-023 Reset during CALC or DONE SHALL abandon the operation with no done_o pulse.

Configuration
REQ-024 The macro INV_CYCLE_COUNT_EN SHALL control a step-count output.
REQ-025 With INV_CYCLE_COUNT_EN defined, the block SHALL add the port cycles_o  output  16. It SHALL hold S for the last operation (0 for a precheck error), update together with done_o, reset to 0, and saturate at 16'hFFFF.
REQ-026 Without INV_CYCLE_COUNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 WIDTH=64, a=3, p=7, start at edge 0 -> done_o at cycle 5, result_o=5, error_o=0, cycles_o=3.
REQ-028 a=1, p=7 -> done_o at cycle 2, result_o=1, cycles_o=0; a=0, p=7 -> done_o at cycle 1, error_o=1, result_o=0.
REQ-029 p=8 (even) -> error_o=1 after 1 cycle; a=3, p=9 -> error_o=1 via u/v=0 in CALC, result_o=0.
REQ-030 a=2, p=2^61-1 -> result_o=64'h1000000000000000, error_o=0, latency at most 4*64+2 cycles.
REQ-031 Assert start_i every cycle during CALC with different operands -> first operation's result is unchanged and the second is accepted only after ready_o returns.
REQ-032 Pull rst_ni low mid-CALC, then restart with a=3, p=7 -> no stray done_o and a correct result of 5.
